drop_scheduler: RTL and testbench
=================================

# drop_scheduler

Gravity scheduler for the falling piece. It divides the system clock into frame ticks and counts frames against a level-dependent drop period. When the period expires it issues a held drop request to the game FSM, which acknowledges it. It sits between the game-control FSM and the board/piece datapath, and also handles soft-drop acceleration and pause.

## Interface
- FRAME_DIV, 833_333: clock cycles per frame tick (60 Hz at 50 MHz); must be ≥ 2.
- SOFT_FRAMES, 2: frames per drop while soft_drop is held; must be ≥ 1.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; (re)starts the scheduler and samples level.
- stop  input  1  single-cycle pulse; returns to IDLE (game over).
- pause  input  1  level; while high, all counting is frozen.
- level  input  4  game level 0–15; sampled on start and at each period reload.
- soft_drop  input  1  level; selects the accelerated period.
- drop_ack  input  1  single-cycle pulse from the game FSM acknowledging drop_req.
- drop_req  output  1  request to move the piece down one row; held until acked.
- frame_tick  output  1  one-cycle pulse per frame; exported for animation.
- busy  output  1  high in every state except IDLE.

## Operation
- States (drop_state_t): IDLE, RUN, PENDING, PAUSED.
- Reset: state IDLE; drop_req, frame_tick, busy all 0; prescaler, frame_cnt, lvl_q and pend_q all 0.
- IDLE: the prescaler is held at 0 and frame_tick stays 0. start → RUN, with lvl_q ← level, frame_cnt ← 0, prescaler ← 0.
- Period: per = soft_drop ? min(DROP_FRAMES[lvl_q], SOFT_FRAMES) : DROP_FRAMES[lvl_q]. It is evaluated combinationally every frame tick, so soft_drop takes effect immediately.
- RUN, on a frame_tick:
  - If frame_cnt + 1 ≥ per → PENDING, drop_req ← 1.
  - Otherwise frame_cnt ← frame_cnt + 1.
  - The ≥ test covers the case where soft_drop rises while frame_cnt already exceeds SOFT_FRAMES; the drop then fires on the next tick.
- PENDING:
  - drop_req stays high and frame ticks keep running, but expirations are not counted and not queued.
  - drop_ack → RUN with drop_req ← 0, frame_cnt ← 0, lvl_q ← level (level changes apply only at reload).
- drop_ack outside PENDING is ignored.
- pause high in RUN or PENDING → PAUSED:
  - pend_q ← (state == PENDING); drop_req forced 0.
  - Prescaler and frame_cnt are frozen; frame_tick stays 0.
- pause low in PAUSED → PENDING if pend_q (drop_req ← 1 again), else RUN. Counting resumes from the frozen values.
- drop_ack while PAUSED is ignored.
- Priority, highest first: stop > start > pause > drop_ack > frame expiry.
  - start in any state restarts cleanly, including mid-PENDING; drop_req drops the next cycle.
  - stop from any state → IDLE with drop_req 0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- frame_tick pulses for 1 cycle when the prescaler wraps from FRAME_DIV−1 to 0, i.e. every FRAME_DIV cycles in RUN/PENDING.
- The first tick after start arrives FRAME_DIV cycles after the start edge.
- drop_req rises in the cycle after the expiring frame_tick.
- drop_req falls in the cycle after drop_ack. The new period starts from the prescaler's current phase; the prescaler is not reset on ack.
- Widths:
  - frame_cnt is 6 bits (table max 48).
  - The prescaler is $clog2(FRAME_DIV) bits and wraps explicitly at FRAME_DIV−1.
  - The compare is done at 7 bits to avoid overflow of frame_cnt + 1.

## Structure
- tetris_pkg holds:
  - typedef enum logic [1:0] drop_state_t {IDLE, RUN, PENDING, PAUSED};
  - DROP_FRAMES[16] = {48,43,38,33,28,23,18,13,8,6,5,5,5,4,4,3}.
- One sub-module, frame_divider: a modulo-FRAME_DIV counter with enable and clear, emitting a wrap pulse. It is instantiated once, with enable = (state ∈ {RUN, PENDING}) and clear = (IDLE | start).
- The FSM, frame_cnt, lvl_q and pend_q live in drop_scheduler.

## Test plan
Use FRAME_DIV=4 and SOFT_FRAMES=2 for all scenarios.
- Reset mid-run: assert reset while drop_req is high → drop_req, frame_tick and busy go 0 immediately (asynchronously); state IDLE.
- Level 0 cadence: start with level=0 → frame_tick every 4 cycles; drop_req rises 1 cycle after the 48th tick (≈193 cycles) and stays high with no ack; ack → drop_req low next cycle; the next request comes 48 ticks later.
- Level 15 with ack delay: level=15, ack 10 cycles after each request → requests spaced 3 ticks plus the ack latency; no double request during PENDING.
- Soft drop late: at level 0 with frame_cnt=20, raise soft_drop → drop_req on the next frame tick; while soft_drop is held, subsequent drops come every 2 ticks.
- Pause: pause during PENDING → drop_req 0, no frame_tick, ack ignored; unpause → drop_req 1 next cycle, ack clears it. Pause during RUN at frame_cnt=5 → resumes counting from 5.
- Start/stop collisions: start and drop_ack in the same cycle → RUN with frame_cnt 0 and the new level. stop in the same cycle as start → IDLE with busy 0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and tables for the falling-piece gravity logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: drop scheduler state encoding and the per-level drop period
// table (frames per row), indexed by game level 0..15.
package tetris_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PENDING = 2'd2,
      PAUSED  = 2'd3
   } drop_state_t;

   // Frames between gravity drops at each level; the largest entry must fit
   // the 6-bit frame counter.
   localparam logic [5:0] DROP_FRAMES [16] = '{
      6'd48, 6'd43, 6'd38, 6'd33, 6'd28, 6'd23, 6'd18, 6'd13,
      6'd8,  6'd6,  6'd5,  6'd5,  6'd5,  6'd4,  6'd4,  6'd3
   };

endpackage

// File: rtl/drop_scheduler_frame_divider.sv
// Modulo-DIV cycle counter that emits a one-cycle wrap pulse (frame tick).
// Latency: wrap is registered; it is high in the cycle after the count leaves DIV-1.
// Backpressure: none; en freezes the count, clr forces it (and the pulse) to 0.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : advance the count this cycle
//   clr        : synchronous clear, dominates en
//   wrap       : registered pulse, one per DIV enabled cycles
module frame_divider #(
   parameter int DIV = 833_333
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int         W    = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else if (en) begin
         // Explicit wrap: DIV is generally not a power of two.
         wrap <= (cnt == LAST);
         cnt  <= (cnt == LAST) ? '0 : cnt + W'(1);
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: rtl/drop_scheduler.sv
// Gravity scheduler: counts frame ticks against a level-dependent period and
// raises a held drop request until the game FSM acknowledges it.
// Latency: drop_req rises the cycle after the expiring frame_tick, falls the cycle after drop_ack.
// Backpressure: while a request is pending further expirations are discarded, not queued.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start, stop : single-cycle pulses; (re)start with level sampled / return to IDLE
//   pause       : level, freezes prescaler and frame count
//   level       : game level, sampled at start and at every ack reload
//   soft_drop   : level, selects the accelerated period
//   drop_ack    : single-cycle acknowledge of drop_req
//   drop_req    : registered request, held until acked
//   frame_tick  : registered one-cycle pulse per frame
//   busy        : registered, high in every state except IDLE
module drop_scheduler
   import tetris_pkg::*;
#(
   parameter int FRAME_DIV   = 833_333,
   parameter int SOFT_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [3:0] level,
   input  logic       soft_drop,
   input  logic       drop_ack,
   output logic       drop_req,
   output logic       frame_tick,
   output logic       busy
);

   localparam logic [6:0] SOFT7 = 7'(SOFT_FRAMES);

   drop_state_t state, state_nxt;
   logic [5:0]  frame_cnt, cnt_nxt;
   logic [3:0]  lvl_q, lvl_nxt;
   logic        pend_q, pend_nxt;
   logic        req_nxt;

   logic [6:0]  base_per;
   logic [6:0]  per;
   logic [6:0]  cnt_inc;
   logic        div_en;
   logic        div_clr;

   // Prescaler only runs while actively scheduling. pause and stop also gate
   // it so that no tick is emitted in the first PAUSED or IDLE cycle.
   assign div_en  = ((state == RUN) || (state == PENDING)) && !pause && !stop;
   assign div_clr = (state == IDLE) || start || stop;

   frame_divider #(
      .DIV (FRAME_DIV)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (div_en),
      .clr   (div_clr),
      .wrap  (frame_tick)
   );

   // Period re-evaluated every tick so soft_drop acts immediately; the
   // compare is 7 bits wide so frame_cnt + 1 cannot overflow.
   assign base_per = {1'b0, DROP_FRAMES[lvl_q]};
   assign per      = (soft_drop && (SOFT7 < base_per)) ? SOFT7 : base_per;
   assign cnt_inc  = {1'b0, frame_cnt} + 7'd1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = frame_cnt;
      lvl_nxt   = lvl_q;
      pend_nxt  = pend_q;
      req_nxt   = drop_req;

      if (stop) begin
         state_nxt = IDLE;
         req_nxt   = 1'b0;
      end else if (start) begin
         state_nxt = RUN;
         lvl_nxt   = level;
         cnt_nxt   = '0;
         req_nxt   = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state_nxt = IDLE;
            end
            RUN: begin
               if (pause) begin
                  state_nxt = PAUSED;
                  pend_nxt  = 1'b0;
                  req_nxt   = 1'b0;
               end else if (frame_tick) begin
                  // >= rather than == catches a period that shrank below
                  // the current count when soft_drop rose.
                  if (cnt_inc >= per) begin
                     state_nxt = PENDING;
                     req_nxt   = 1'b1;
                  end else begin
                     cnt_nxt = cnt_inc[5:0];
                  end
               end
            end
            PENDING: begin
               if (pause) begin
                  state_nxt = PAUSED;
                  pend_nxt  = 1'b1;
                  req_nxt   = 1'b0;
               end else if (drop_ack) begin
                  state_nxt = RUN;
                  req_nxt   = 1'b0;
                  cnt_nxt   = '0;
                  lvl_nxt   = level;
               end
            end
            PAUSED: begin
               if (!pause) begin
                  state_nxt = pend_q ? PENDING : RUN;
                  req_nxt   = pend_q;
               end
            end
            default: begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         frame_cnt <= '0;
         lvl_q     <= '0;
         pend_q    <= 1'b0;
         drop_req  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= cnt_nxt;
         lvl_q     <= lvl_nxt;
         pend_q    <= pend_nxt;
         drop_req  <= req_nxt;
         busy      <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_drop_scheduler.sv
// Bench for drop_scheduler with FRAME_DIV=4, SOFT_FRAMES=2.
// A behavioural model predicts drop_req/frame_tick/busy for every cycle and
// queues the prediction; an independent monitor compares on the falling edge.
module tb_drop_scheduler;

   localparam int FD = 4;
   localparam int SF = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] level = 4'd0;
   logic       soft_drop = 1'b0;
   logic       drop_ack = 1'b0;
   logic       drop_req;
   logic       frame_tick;
   logic       busy;

   drop_scheduler #(
      .FRAME_DIV   (FD),
      .SOFT_FRAMES (SF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .level      (level),
      .soft_drop  (soft_drop),
      .drop_ack   (drop_ack),
      .drop_req   (drop_req),
      .frame_tick (frame_tick),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int    cyc;
      bit    req;
      bit    tick;
      bit    bsy;
      string tag;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    errors = 0;
   int    checks = 0;
   string tag = "reset";

   int drop_tbl[16] = '{48, 43, 38, 33, 28, 23, 18, 13, 8, 6, 5, 5, 5, 4, 4, 3};

   // ---------------- reference model ----------------
   // Modes: 0 idle, 1 counting, 2 waiting for ack, 3 paused.
   int m_mode, m_phase, m_frames, m_lvl;
   bit m_pend, m_req, m_tick, m_busy;

   task automatic model_reset();
      m_mode = 0; m_phase = 0; m_frames = 0; m_lvl = 0;
      m_pend = 0; m_req = 0; m_tick = 0; m_busy = 0;
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_step();
      int  period;
      int  mode;
      bit  counting;
      bit  ntick;
      int  nphase;
      period = drop_tbl[m_lvl];
      if (soft_drop && SF < period) period = SF;

      // Frame clock: runs only while scheduling and not paused/stopped.
      counting = (m_mode == 1 || m_mode == 2) && !pause && !stop;
      ntick  = 0;
      nphase = m_phase;
      if (m_mode == 0 || start || stop) nphase = 0;
      else if (counting) begin
         ntick  = (m_phase == FD - 1);
         nphase = (m_phase + 1) % FD;
      end

      mode = m_mode;
      if (stop) begin
         mode = 0; m_req = 0;
      end else if (start) begin
         mode = 1; m_lvl = level; m_frames = 0; m_req = 0;
      end else if (m_mode == 1) begin
         if (pause) begin
            mode = 3; m_pend = 0; m_req = 0;
         end else if (m_tick) begin
            if (m_frames + 1 >= period) begin mode = 2; m_req = 1; end
            else m_frames = m_frames + 1;
         end
      end else if (m_mode == 2) begin
         if (pause) begin
            mode = 3; m_pend = 1; m_req = 0;
         end else if (drop_ack) begin
            mode = 1; m_req = 0; m_frames = 0; m_lvl = level;
         end
      end else if (m_mode == 3) begin
         if (!pause) begin
            mode = m_pend ? 2 : 1; m_req = m_pend;
         end
      end
      m_mode  = mode;
      m_phase = nphase;
      m_tick  = ntick;
      m_busy  = (mode != 0);
   endtask

   task automatic push_exp(input int c);
      exp_t e;
      e.cyc = c; e.req = m_req; e.tick = m_tick; e.bsy = m_busy; e.tag = tag;
      sb.push_back(e);
   endtask

   // Called at posedge+1 with inputs set; leaves at the next posedge+1.
   task automatic cycle_();
      model_step();
      push_exp(cyc + 1);
      @(posedge clk);
      #1;
      start = 0; stop = 0; drop_ack = 0;
   endtask

   task automatic run(input int n);
      repeat (n) cycle_();
   endtask

   task automatic wait_req();
      for (int i = 0; i < 400 && !m_req; i++) cycle_();
   endtask

   task automatic do_start(input logic [3:0] lv);
      level = lv; start = 1; cycle_();
   endtask

   task automatic ack_after(input int d);
      wait_req();
      run(d);
      drop_ack = 1;
      cycle_();
   endtask

   // Asynchronous reset mid-cycle: outputs must clear before the falling edge.
   task automatic do_reset();
      if (sb.size() > 0 && sb[sb.size()-1].cyc == cyc) sb.pop_back();
      reset = 1;
      model_reset();
      push_exp(cyc);
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if ({drop_req, frame_tick, busy} !== {mon_e.req, mon_e.tick, mon_e.bsy}) begin
               errors++;
               $display("FAIL %s cyc=%0d req/tick/busy got=%b%b%b want=%b%b%b",
                        mon_e.tag, mon_e.cyc, drop_req, frame_tick, busy,
                        mon_e.req, mon_e.tick, mon_e.bsy);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int ackw;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 0;
      tag = "reset state";
      push_exp(cyc);
      run(3);

      tag = "level0 cadence";
      do_start(4'd0);
      run(210);
      drop_ack = 1; cycle_();
      run(200);
      drop_ack = 1; cycle_();

      tag = "level15 ack delay";
      do_start(4'd15);
      repeat (4) ack_after(10);

      tag = "soft drop late";
      do_start(4'd0);
      run(82);
      soft_drop = 1;
      repeat (4) ack_after(2);
      soft_drop = 0;

      tag = "pause pending";
      do_start(4'd15);
      wait_req();
      pause = 1; run(6);
      drop_ack = 1; cycle_();
      run(3);
      pause = 0; run(3);
      drop_ack = 1; cycle_();

      tag = "pause run";
      do_start(4'd0);
      run(22);
      pause = 1; run(10);
      pause = 0; run(30);

      tag = "start+ack collision";
      do_start(4'd15);
      wait_req();
      level = 4'd7; start = 1; drop_ack = 1; cycle_();
      run(40);

      tag = "start+stop collision";
      start = 1; stop = 1; cycle_();
      run(6);

      tag = "reset mid-run";
      do_start(4'd15);
      wait_req();
      run(2);
      do_reset();
      run(5);

      tag = "random";
      do_start(4'd5);
      ackw = 3;
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(399) == 0) begin start = 1; level = 4'($urandom_range(15)); end
         if ($urandom_range(1499) == 0) stop = 1;
         if ($urandom_range(59) == 0) pause = !pause;
         if ($urandom_range(79) == 0) soft_drop = !soft_drop;
         if ($urandom_range(19) == 0) level = 4'($urandom_range(15));
         if (m_req) begin
            if (ackw == 0) begin drop_ack = 1; ackw = $urandom_range(12); end
            else ackw--;
         end else if ($urandom_range(49) == 0) begin
            drop_ack = 1;
         end
         cycle_();
      end
      pause = 0;
      run(5);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d predictions left uncompared, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
